nonce_result_queue: RTL and testbench

Downstream of the hash/compare worker in the hash clock domain. Tracks which nonce each compare result belongs to and queues winning nonces in a small FIFO. Drains the FIFO one 32-bit word at a time into the serial transmitter over a send/busy handshake, so back-to-back hits are not lost while the UART is busy.

---
 rtl/miner_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/nonce_result_queue.sv | 114 +++++++++++
 tb/tb_nonce_result_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared miner constants and types: nonce width, nonce sequence defaults and TX FSM states.
// The nonce generator imports the same defaults, so the generator and the result tracker walk one sequence.
package miner_pkg;

  localparam int NONCE_W = 32;

  localparam logic [NONCE_W-1:0] DEFAULT_NONCE_INIT   = 32'd12;
  localparam logic [NONCE_W-1:0] DEFAULT_NONCE_STRIDE = 32'd13;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  // Nonces advance by a fixed stride and wrap modulo 2^NONCE_W.
  function automatic logic [NONCE_W-1:0] next_nonce(
    input logic [NONCE_W-1:0] cur,
    input logic [NONCE_W-1:0] stride
  );
    return cur + stride;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and a DEPTH+1 state occupancy count.
// A push into a full FIFO only succeeds when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only read after a push has filled the slot.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/nonce_result_queue.sv
// Attaches nonces to compare results, queues winning nonces and drains them one word at a time
// to the serial transmitter over a send/busy handshake.
module nonce_result_queue
  import miner_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_INIT   = DEFAULT_NONCE_INIT,
  parameter logic [NONCE_W-1:0] NONCE_STRIDE = DEFAULT_NONCE_STRIDE,
  parameter int                 DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_start,
  input  logic                   res_valid,
  input  logic                   res_hit,
  input  logic                   busy,
  output logic                   send,
  output logic [NONCE_W-1:0]     word,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  logic [NONCE_W-1:0] tracker_q, tracker_d;
  logic [NONCE_W-1:0] word_q, word_d;
  logic               send_q, send_d;
  logic               overflow_q, overflow_d;
  tx_state_t          state_q, state_d;

  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [NONCE_W-1:0] fifo_dout;

  // A new job discards any result strobe arriving in the same cycle.
  assign push = res_valid && res_hit && !job_start;

  sync_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (job_start),
    .push  (push),
    .pop   (pop),
    .din   (tracker_q),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tracker_d  = tracker_q;
    overflow_d = overflow_q;
    if (job_start) begin
      tracker_d  = NONCE_INIT;
      overflow_d = 1'b0;
    end else begin
      if (res_valid) tracker_d = next_nonce(tracker_q, NONCE_STRIDE);
      if (push && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  // An in-flight word is left alone by job_start; only a fresh pop is suppressed.
  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!job_start && !fifo_empty && !busy) begin
          pop     = 1'b1;
          word_d  = fifo_dout;
          send_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (busy) begin
          send_d  = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_d = IDLE;
      end
      default: begin
        send_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tracker_q  <= NONCE_INIT;
      word_q     <= '0;
      send_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      tracker_q  <= tracker_d;
      word_q     <= word_d;
      send_q     <= send_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  assign send     = send_q;
  assign word     = word_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_nonce_result_queue.sv
// Self-checking bench for nonce_result_queue: a vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model of the result path.
module tb_nonce_result_queue;

  logic        clk;
  logic        rst, job_start, res_valid, res_hit, busy;
  logic        send, overflow;
  logic [31:0] word;
  logic [3:0]  count;
  logic        send_w, overflow_w;
  logic [31:0] word_w;
  logic [3:0]  count_w;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rx_q[$];
  logic [31:0] rx_wrap_q[$];

  nonce_result_queue u_dut (
    .clk(clk), .rst(rst), .job_start(job_start), .res_valid(res_valid),
    .res_hit(res_hit), .busy(busy), .send(send), .word(word),
    .count(count), .overflow(overflow)
  );

  nonce_result_queue #(.NONCE_INIT(32'hFFFF_FFF5)) u_dut_wrap (
    .clk(clk), .rst(rst), .job_start(job_start), .res_valid(res_valid),
    .res_hit(res_hit), .busy(busy), .send(send_w), .word(word_w),
    .count(count_w), .overflow(overflow_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, js, rv, rh, bz;
    logic        exp_send;
    logic [31:0] exp_word;
    logic [3:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[25];

  // Drive one cycle of inputs, let the edge happen, and leave outputs settled for sampling.
  task automatic applyStimulus(input logic r, input logic js, input logic rv, input logic rh, input logic bz);
    rst = r; job_start = js; res_valid = rv; res_hit = rh; busy = bz;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Act as the transmitter for n words: wait (bounded) for send, record word, pulse busy.
  task automatic drainWords(input int n);
    int budget;
    rx_q.delete();
    rx_wrap_q.delete();
    for (int k = 0; k < n; k++) begin
      budget = 30;
      while (send !== 1'b1 && budget > 0) begin
        applyStimulus(0, 0, 0, 0, 0);
        budget--;
      end
      if (send !== 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL drain_timeout: got send=%b, expected send=1 within 30 cycles", send);
        return;
      end
      rx_q.push_back(word);
      rx_wrap_q.push_back(word_w);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("drain_send_drop", {31'd0, send}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0);
    end
  endtask

  // Reference model: an ideal queue plus the request/acknowledge protocol of the transmitter link.
  logic [31:0] m_q[$];
  logic [31:0] m_tracker, m_word;
  bit          m_send, m_wait, m_ovf;

  task automatic modelReset();
    m_q.delete();
    m_tracker = 32'd12;
    m_word = 32'd0;
    m_send = 0;
    m_wait = 0;
    m_ovf = 0;
  endtask

  task automatic modelStep(input bit js, input bit rv, input bit rh, input bit bz);
    if (m_send) begin
      if (bz) begin m_send = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (!bz) m_wait = 0;
    end else if (!js && m_q.size() > 0 && !bz) begin
      m_word = m_q.pop_front();
      m_send = 1;
    end
    if (js) begin
      m_q.delete();
      m_ovf = 0;
      m_tracker = 32'd12;
    end else if (rv) begin
      if (rh) begin
        if (m_q.size() < 8) m_q.push_back(m_tracker);
        else m_ovf = 1;
      end
      m_tracker = m_tracker + 32'd13;
    end
  endtask

  initial begin
    int busy_cnt;
    bit js, rv, rh, bz;

    rst = 1; job_start = 0; res_valid = 0; res_hit = 0; busy = 0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_send", {31'd0, send}, 32'd0);
    checkOutput("reset_word", word, 32'd0);
    checkOutput("reset_count", {28'd0, count}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);

    $display("[TB] single hit on 3rd strobe, then three hits under busy");
    vecs[0]  = '{0,0,1,0,0, 0, 32'd0,  4'd0, 0};
    vecs[1]  = '{0,0,1,0,0, 0, 32'd0,  4'd0, 0};
    vecs[2]  = '{0,0,1,1,0, 0, 32'd0,  4'd1, 0};
    vecs[3]  = '{0,0,1,0,0, 1, 32'd38, 4'd0, 0};
    vecs[4]  = '{0,0,1,0,0, 1, 32'd38, 4'd0, 0};
    vecs[5]  = '{0,0,0,0,0, 1, 32'd38, 4'd0, 0};
    vecs[6]  = '{0,0,0,0,1, 0, 32'd38, 4'd0, 0};
    vecs[7]  = '{0,0,0,0,1, 0, 32'd38, 4'd0, 0};
    vecs[8]  = '{0,0,0,0,0, 0, 32'd38, 4'd0, 0};
    vecs[9]  = '{0,0,0,0,0, 0, 32'd38, 4'd0, 0};
    vecs[10] = '{1,0,0,0,0, 0, 32'd0,  4'd0, 0};
    vecs[11] = '{0,0,1,1,1, 0, 32'd0,  4'd1, 0};
    vecs[12] = '{0,0,1,1,1, 0, 32'd0,  4'd2, 0};
    vecs[13] = '{0,0,1,1,1, 0, 32'd0,  4'd3, 0};
    vecs[14] = '{0,0,0,0,1, 0, 32'd0,  4'd3, 0};
    vecs[15] = '{0,0,0,0,0, 1, 32'd12, 4'd2, 0};
    vecs[16] = '{0,0,0,0,0, 1, 32'd12, 4'd2, 0};
    vecs[17] = '{0,0,0,0,1, 0, 32'd12, 4'd2, 0};
    vecs[18] = '{0,0,0,0,0, 0, 32'd12, 4'd2, 0};
    vecs[19] = '{0,0,0,0,0, 1, 32'd25, 4'd1, 0};
    vecs[20] = '{0,0,0,0,1, 0, 32'd25, 4'd1, 0};
    vecs[21] = '{0,0,0,0,0, 0, 32'd25, 4'd1, 0};
    vecs[22] = '{0,0,0,0,0, 1, 32'd38, 4'd0, 0};
    vecs[23] = '{0,0,0,0,1, 0, 32'd38, 4'd0, 0};
    vecs[24] = '{0,0,0,0,0, 0, 32'd38, 4'd0, 0};
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].js, vecs[i].rv, vecs[i].rh, vecs[i].bz);
      checkOutput($sformatf("vec%0d_send", i), {31'd0, send}, {31'd0, vecs[i].exp_send});
      checkOutput($sformatf("vec%0d_word", i), word, vecs[i].exp_word);
      checkOutput($sformatf("vec%0d_count", i), {28'd0, count}, {28'd0, vecs[i].exp_count});
      checkOutput($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
    end

    $display("[TB] overflow with 10 hits into 8 entries");
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 1, 1);
    checkOutput("ovf_count", {28'd0, count}, 32'd8);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    drainWords(8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("ovf_word%0d", k), (k < rx_q.size()) ? rx_q[k] : 32'hDEAD_BEEF, 32'd12 + 32'd13 * k);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ovf_no_extra_send", {31'd0, send}, 32'd0);
    checkOutput("ovf_drained_count", {28'd0, count}, 32'd0);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

    $display("[TB] tracker wrap");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    drainWords(2);
    checkOutput("wrap_word0", (rx_wrap_q.size() > 0) ? rx_wrap_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF5);
    checkOutput("wrap_word1", (rx_wrap_q.size() > 1) ? rx_wrap_q[1] : 32'hDEAD_BEEF, 32'h0000_0002);
    checkOutput("wrap_ref_word1", (rx_q.size() > 1) ? rx_q[1] : 32'hDEAD_BEEF, 32'd25);
    checkOutput("wrap_count", {28'd0, count_w}, 32'd0);
    checkOutput("wrap_overflow", {31'd0, overflow_w}, 32'd0);

    $display("[TB] job_start during SEND");
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("js_send_pre", {31'd0, send}, 32'd1);
    checkOutput("js_count_pre", {28'd0, count}, 32'd2);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("js_send_held", {31'd0, send}, 32'd1);
    checkOutput("js_word_held", word, 32'd12);
    checkOutput("js_count_flushed", {28'd0, count}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("js_send_done", {31'd0, send}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("js_no_resend", {31'd0, send}, 32'd0);
    applyStimulus(0, 0, 1, 1, 0);
    drainWords(1);
    checkOutput("js_first_hit", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, 32'd12);

    $display("[TB] reset in WAIT_DONE and SEND, job_start with result");
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rstw_count_pre", {28'd0, count}, 32'd1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("rstw_send", {31'd0, send}, 32'd0);
    checkOutput("rstw_count", {28'd0, count}, 32'd0);
    checkOutput("rstw_word", word, 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rstw_idle", {31'd0, send}, 32'd0);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rsts_send_pre", {31'd0, send}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rsts_send", {31'd0, send}, 32'd0);
    checkOutput("rsts_count", {28'd0, count}, 32'd0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("jsv_count", {28'd0, count}, 32'd0);
    checkOutput("jsv_send", {31'd0, send}, 32'd0);
    applyStimulus(0, 0, 1, 1, 0);
    drainWords(1);
    checkOutput("jsv_first_hit", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD_BEEF, 32'd12);

    $display("[TB] randomized traffic against reference model");
    applyStimulus(1, 0, 0, 0, 0);
    modelReset();
    busy_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      js = ($urandom_range(99) == 0);
      rv = ($urandom_range(1) == 1);
      rh = ($urandom_range(2) == 0);
      if (busy_cnt > 0) begin
        bz = 1; busy_cnt--;
      end else if (send === 1'b1 && $urandom_range(1) == 1) begin
        bz = 1; busy_cnt = $urandom_range(3);
      end else if ($urandom_range(9) == 0) begin
        bz = 1; busy_cnt = $urandom_range(2);
      end else begin
        bz = 0;
      end
      modelStep(js, rv, rh, bz);
      applyStimulus(0, js, rv, rh, bz);
      checkOutput($sformatf("rnd%0d_send", cyc), {31'd0, send}, {31'd0, m_send});
      checkOutput($sformatf("rnd%0d_word", cyc), word, m_word);
      checkOutput($sformatf("rnd%0d_count", cyc), {28'd0, count}, m_q.size());
      checkOutput($sformatf("rnd%0d_overflow", cyc), {31'd0, overflow}, {31'd0, m_ovf});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
